decoder_3_8_hold_seq: RTL and testbench
=======================================

// Module: decoder_3_8_hold_seq
// PURPOSE
//   Sequential 3-to-8 decoder: receiver end of the 3-bit code stream from an 8-to-3 priority encoder.
//   Accepts codes through a valid/ready handshake and buffers them in a small FIFO.
//   Drives each code as a one-hot 8-bit pattern held for HOLD_CYCLES clocks, back-to-back.
//   Used to rebuild one-hot select/strobe lines from encoded requests.
// PARAMETERS
//   HOLD_CYCLES  4  clocks each one-hot pattern is held; legal range 1..255
//   FIFO_DEPTH   2  input queue depth, in codes; power of 2, >= 2
// PORTS
//   clk         in   1  rising-edge clock
//   rst         in   1  asynchronous, active-high reset
//   in_valid    in   1  in_code is valid this cycle
//   in_code     in   3  binary index 0..7
//   in_ready    out  1  queue can accept a code this cycle
//   en          in   1  1 = new codes may be popped; 0 = hold off
//   out         out  8  one-hot decoded pattern; 8'h00 when idle
//   out_busy    out  1  1 while a pattern is being held
//   code_count  out  8  number of patterns driven since reset; wraps 255->0
// BEHAVIOUR
//   Reset (async, rst=1): out=8'h00, out_busy=0, code_count=0, FIFO empty, in_ready=1, FSM=IDLE, timer=0.
//     Applies immediately, including mid-hold. After rst falls, normal operation resumes on the next clk edge.
//   Handshake: a code transfers on the clk edge where in_valid & in_ready.
//     in_ready = !fifo_full, decoded from registered FIFO state only.
//     A pop in the same cycle does NOT raise in_ready (no pass-through).
//     in_code is ignored when in_valid=0 or in_ready=0. A refused code is neither dropped nor duplicated.
//   FIFO: write/read pointers wrap modulo FIFO_DEPTH. Push and pop in one cycle are both legal when not full.
//     Occupancy counts 0..FIFO_DEPTH.
//   FSM:
//     IDLE: out=0, out_busy=0.
//       If fifo non-empty & en at an edge: pop, out<=1<<code, timer<=HOLD_CYCLES-1,
//       code_count<=code_count+1, go to HOLD.
//     HOLD: out held, out_busy=1.
//       If timer!=0: timer<=timer-1.
//       If timer==0 & fifo non-empty & en: pop and load the next pattern in the same edge (no gap cycle),
//         reload timer, increment code_count.
//       If timer==0 & (empty | !en): out<=0, go to IDLE.
//   Latency: code accepted at edge k into an empty FIFO while IDLE -> out valid from edge k+1.
//     Held exactly HOLD_CYCLES clocks; cleared or replaced at edge k+1+HOLD_CYCLES.
//   en=0 never truncates a hold in progress. It only blocks the next pop.
//   HOLD_CYCLES=1: a new pattern every clock while the queue is non-empty and en=1.
//   out always carries exactly one set bit or all zeros, never more than one bit.
//   code_count is an 8-bit unsigned counter; increments once per pattern load; wraps 255->0, no saturation.
// TESTING
//   1. HOLD=4: reset, push code 3 at edge k -> out=8'h08 for edges k+1..k+5 (4 clocks), then 8'h00.
//      out_busy mirrors this; code_count=1.
//   2. Push codes 0..7 with in_valid held high -> in_ready falls whenever 2 codes are queued.
//      out = 01,02,04,...,80, 4 clocks each, no gap cycles; code_count=8; no code lost.
//   3. en=0, push 5 -> out stays 8'h00, in_ready=1. Raise en -> out=8'h20 one edge later.
//      en low mid-hold -> hold completes, then out=8'h00.
//   4. rst pulse during the hold of code 6 with 2 codes queued -> out=8'h00, in_ready=1, code_count=0
//      without any clk edge. Next push of 2 -> out=8'h04.
//   5. FIFO full, in_valid=1 with code 7 while in_ready=0 -> code 7 not taken.
//      Once ready rises it is accepted exactly once and appears exactly once on out.
//   6. Loopback: feed out into priority_encoder_8_3 -> encoder output equals each pushed code for every clock
//      of its hold, for all 8 codes, HOLD=1 and HOLD=4.

Source files
------------

// File: rtl/decoder_3_8_hold_seq.sv
`default_nettype none
// ============================================================================
// Module   : decoder_3_8_hold_seq
// Brief    : Sequential 3-to-8 decoder. Buffers 3-bit codes from a
//            valid/ready stream in a small FIFO and drives each one as a
//            one-hot pattern held for HOLD_CYCLES clocks, back-to-back.
// Revision : 1.0  initial release
// ============================================================================
module decoder_3_8_hold_seq #(
    parameter int HOLD_CYCLES = 4,   // 1..255
    parameter int FIFO_DEPTH  = 2    // power of 2, >= 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [2:0] in_code,
    output logic       in_ready,
    input  logic       en,
    output logic [7:0] out,
    output logic       out_busy,
    output logic [7:0] code_count
);

    localparam int                 c_PTR_W      = $clog2(FIFO_DEPTH);
    localparam int                 c_OCC_W      = $clog2(FIFO_DEPTH + 1);
    localparam logic [c_OCC_W-1:0] c_OCC_FULL   = c_OCC_W'(FIFO_DEPTH);
    localparam logic [7:0]         c_TIMER_LOAD = 8'(HOLD_CYCLES - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    logic [2:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_OCC_W-1:0] r_occ;

    state_t             r_state;
    logic [7:0]         r_timer;
    logic [7:0]         r_out;
    logic               r_busy;
    logic [7:0]         r_count;

    logic               w_push;
    logic               w_pop;
    logic               w_empty;
    logic               w_full;
    logic               w_slot_free;
    logic [2:0]         w_head;
    logic [7:0]         w_onehot;

    // Ready depends only on registered occupancy, so a same-cycle pop
    // never lets a code slip straight through a full queue.
    assign w_full      = (r_occ == c_OCC_FULL);
    assign w_empty     = (r_occ == '0);
    assign in_ready    = ~w_full;
    assign w_push      = in_valid & ~w_full;

    // A new pattern may load when idle, or on the last clock of a hold.
    assign w_slot_free = (r_state == S_IDLE) || (r_timer == 8'd0);
    assign w_pop       = w_slot_free & ~w_empty & en;
    assign w_head      = r_mem[r_rd_ptr];
    assign w_onehot    = 8'h01 << w_head;

    assign out         = r_out;
    assign out_busy    = r_busy;
    assign code_count  = r_count;

    // Storage array: written on every accepted code, contents need no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_code;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_occ <= r_occ + c_OCC_W'(1);
            end else if (w_pop && !w_push) begin
                r_occ <= r_occ - c_OCC_W'(1);
            end
        end
    end

    // Output FSM: load a pattern, count down the hold, then reload or go idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_timer <= 8'd0;
            r_out   <= 8'h00;
            r_busy  <= 1'b0;
            r_count <= 8'd0;
        end else if (w_pop) begin
            // Covers both the first load from IDLE and the gapless reload.
            r_state <= S_HOLD;
            r_timer <= c_TIMER_LOAD;
            r_out   <= w_onehot;
            r_busy  <= 1'b1;
            r_count <= r_count + 8'd1;
        end else if (r_state == S_HOLD) begin
            if (r_timer != 8'd0) begin
                r_timer <= r_timer - 8'd1;
            end else begin
                r_state <= S_IDLE;
                r_out   <= 8'h00;
                r_busy  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decoder_3_8_hold_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_decoder_3_8_hold_seq
// Brief    : Directed bench for decoder_3_8_hold_seq (HOLD=4 and HOLD=1).
// Revision : 1.0  initial release
// ============================================================================
module tb_decoder_3_8_hold_seq;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       v4 = 1'b0;
    logic [2:0] c4 = 3'd0;
    logic       e4 = 1'b1;
    logic       ready4;
    logic [7:0] out4;
    logic       busy4;
    logic [7:0] cnt4;

    logic       v1 = 1'b0;
    logic [2:0] c1 = 3'd0;
    logic       e1 = 1'b1;
    logic       ready1;
    logic [7:0] out1;
    logic       busy1;
    logic [7:0] cnt1;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];

    typedef struct {
        logic       v;
        logic [2:0] c;
        logic       e;
        logic [7:0] o;
        logic       rdy;
        logic       busy;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    decoder_3_8_hold_seq #(.HOLD_CYCLES(HOLD), .FIFO_DEPTH(2)) u4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in_code(c4), .in_ready(ready4),
        .en(e4), .out(out4), .out_busy(busy4), .code_count(cnt4)
    );

    decoder_3_8_hold_seq #(.HOLD_CYCLES(1), .FIFO_DEPTH(2)) u1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_code(c1), .in_ready(ready1),
        .en(e1), .out(out1), .out_busy(busy1), .code_count(cnt1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Priority encoder model used for the loopback check.
    function automatic int penc(input logic [7:0] x);
        for (int b = 7; b >= 0; b--) begin
            if (x[b]) return b;
        end
        return -1;
    endfunction

    function automatic vec_t mk(input logic v, input logic [2:0] c, input logic e,
                                input logic [7:0] o, input logic rdy, input logic busy,
                                input logic [7:0] cnt);
        vec_t r;
        r.v = v; r.c = c; r.e = e; r.o = o; r.rdy = rdy; r.busy = busy; r.cnt = cnt;
        return r;
    endfunction

    // Walks the u4 output through the codes in exp_q, HOLD samples each,
    // starting at sample index 'skip', then expects idle.
    task automatic check_stream(input int skip);
        int n;
        int code;
        n = exp_q.size() * HOLD;
        for (int i = skip; i < n; i++) begin
            code = exp_q[i / HOLD];
            chk($sformatf("stream[%0d].out", i), {24'd0, out4}, 32'(1) << code);
            chk($sformatf("stream[%0d].enc", i), penc(out4), code);
            chk($sformatf("stream[%0d].busy", i), {31'd0, busy4}, 1);
            step();
        end
        chk("stream.end_out", {24'd0, out4}, 0);
        chk("stream.end_busy", {31'd0, busy4}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        rst = 1'b1;
        step(); step();
        chk("rst.out",   {24'd0, out4}, 0);
        chk("rst.ready", {31'd0, ready4}, 1);
        chk("rst.busy",  {31'd0, busy4}, 0);
        chk("rst.cnt",   {24'd0, cnt4}, 0);
        chk("rst.out1",  {24'd0, out1}, 0);
        rst = 1'b0;

        // ---------------- table: single code, en gating ----------------
        //               v     c     e     out    rdy   busy  cnt
        tbl.push_back(mk(1'b1, 3'd3, 1'b1, 8'h00, 1'b1, 1'b0, 8'd0));
        tbl.push_back(mk(1'b0, 3'd0, 1'b1, 8'h08, 1'b1, 1'b1, 8'd1));
        tbl.push_back(mk(1'b0, 3'd0, 1'b1, 8'h08, 1'b1, 1'b1, 8'd1));
        tbl.push_back(mk(1'b0, 3'd0, 1'b1, 8'h08, 1'b1, 1'b1, 8'd1));
        tbl.push_back(mk(1'b0, 3'd0, 1'b1, 8'h08, 1'b1, 1'b1, 8'd1));
        tbl.push_back(mk(1'b0, 3'd0, 1'b1, 8'h00, 1'b1, 1'b0, 8'd1));
        tbl.push_back(mk(1'b1, 3'd5, 1'b0, 8'h00, 1'b1, 1'b0, 8'd1));
        tbl.push_back(mk(1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0, 8'd1));
        tbl.push_back(mk(1'b0, 3'd0, 1'b1, 8'h20, 1'b1, 1'b1, 8'd2));
        tbl.push_back(mk(1'b1, 3'd1, 1'b0, 8'h20, 1'b1, 1'b1, 8'd2));
        tbl.push_back(mk(1'b0, 3'd0, 1'b0, 8'h20, 1'b1, 1'b1, 8'd2));
        tbl.push_back(mk(1'b0, 3'd0, 1'b0, 8'h20, 1'b1, 1'b1, 8'd2));
        tbl.push_back(mk(1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0, 8'd2));
        tbl.push_back(mk(1'b0, 3'd0, 1'b1, 8'h02, 1'b1, 1'b1, 8'd3));
        tbl.push_back(mk(1'b0, 3'd0, 1'b1, 8'h02, 1'b1, 1'b1, 8'd3));
        tbl.push_back(mk(1'b0, 3'd0, 1'b1, 8'h02, 1'b1, 1'b1, 8'd3));
        tbl.push_back(mk(1'b0, 3'd0, 1'b1, 8'h02, 1'b1, 1'b1, 8'd3));
        tbl.push_back(mk(1'b0, 3'd0, 1'b1, 8'h00, 1'b1, 1'b0, 8'd3));

        for (int i = 0; i < tbl.size(); i++) begin
            v4 = tbl[i].v;
            c4 = tbl[i].c;
            e4 = tbl[i].e;
            step();
            chk($sformatf("vec[%0d].out", i),   {24'd0, out4},   {24'd0, tbl[i].o});
            chk($sformatf("vec[%0d].ready", i), {31'd0, ready4}, {31'd0, tbl[i].rdy});
            chk($sformatf("vec[%0d].busy", i),  {31'd0, busy4},  {31'd0, tbl[i].busy});
            chk($sformatf("vec[%0d].cnt", i),   {24'd0, cnt4},   {24'd0, tbl[i].cnt});
        end
        v4 = 1'b0;

        // ---------------- refused code while full ----------------
        e4 = 1'b0;
        v4 = 1'b1; c4 = 3'd1; step();
        v4 = 1'b1; c4 = 3'd2; step();
        chk("full.ready", {31'd0, ready4}, 0);
        for (int i = 0; i < 3; i++) begin
            v4 = 1'b1; c4 = 3'd7; step();
            chk($sformatf("full[%0d].ready", i), {31'd0, ready4}, 0);
            chk($sformatf("full[%0d].out", i),   {24'd0, out4}, 0);
        end
        e4 = 1'b1; step();
        chk("full.pop_out",   {24'd0, out4}, 8'h02);
        chk("full.pop_ready", {31'd0, ready4}, 1);
        chk("full.pop_cnt",   {24'd0, cnt4}, 4);
        step();
        chk("full.take7_ready", {31'd0, ready4}, 0);
        v4 = 1'b0;
        exp_q = '{1, 2, 7};
        check_stream(1);
        chk("full.cnt", {24'd0, cnt4}, 6);

        // ---------------- streaming 0..7 with back-pressure ----------------
        fork
            begin : prod
                int idx;
                int guard;
                int low;
                logic r;
                idx = 0; guard = 0; low = 0;
                while (idx < 8 && guard < 200) begin
                    v4 = 1'b1;
                    c4 = idx[2:0];
                    r  = ready4;
                    if (!r) low++;
                    step();
                    if (r) idx++;
                    guard++;
                end
                v4 = 1'b0;
                chk("burst.all_pushed", idx, 8);
                chk("burst.ready_fell", {31'd0, (low > 0)}, 1);
            end
            begin : cons
                int w;
                w = 0;
                while (out4 == 8'h00 && w < 20) begin
                    step();
                    w++;
                end
                chk("burst.started", {31'd0, (out4 != 8'h00)}, 1);
                exp_q = '{0, 1, 2, 3, 4, 5, 6, 7};
                check_stream(0);
            end
        join
        chk("burst.cnt", {24'd0, cnt4}, 14);

        // ---------------- async reset mid-hold ----------------
        v4 = 1'b1; c4 = 3'd6; step();
        v4 = 1'b1; c4 = 3'd1; step();
        chk("rst2.holding6", {24'd0, out4}, 8'h40);
        v4 = 1'b1; c4 = 3'd2; step();
        v4 = 1'b0;
        chk("rst2.queue_full", {31'd0, ready4}, 0);
        #2 rst = 1'b1;
        #1;
        chk("rst2.out",   {24'd0, out4}, 0);
        chk("rst2.ready", {31'd0, ready4}, 1);
        chk("rst2.busy",  {31'd0, busy4}, 0);
        chk("rst2.cnt",   {24'd0, cnt4}, 0);
        #1 rst = 1'b0;
        step();
        chk("rst2.idle_after", {24'd0, out4}, 0);
        v4 = 1'b1; c4 = 3'd2; step();
        v4 = 1'b0; step();
        chk("rst2.push2_out", {24'd0, out4}, 8'h04);
        chk("rst2.push2_cnt", {24'd0, cnt4}, 1);
        step(); step(); step();
        chk("rst2.still2", {24'd0, out4}, 8'h04);
        step();
        chk("rst2.no_stale_out", {24'd0, out4}, 0);
        chk("rst2.no_stale_cnt", {24'd0, cnt4}, 1);

        // ---------------- HOLD=1 loopback, one pattern per clock ----------------
        for (int i = 0; i < 8; i++) begin
            v1 = 1'b1;
            c1 = 3'(i);
            step();
            chk($sformatf("h1[%0d].ready", i), {31'd0, ready1}, 1);
            if (i > 0) begin
                chk($sformatf("h1[%0d].out", i), {24'd0, out1}, 32'(1) << (i - 1));
                chk($sformatf("h1[%0d].enc", i), penc(out1), i - 1);
            end
        end
        v1 = 1'b0;
        step();
        chk("h1.last_out", {24'd0, out1}, 8'h80);
        chk("h1.last_enc", penc(out1), 7);
        step();
        chk("h1.end_out",  {24'd0, out1}, 0);
        chk("h1.end_busy", {31'd0, busy1}, 0);
        chk("h1.cnt",      {24'd0, cnt1}, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
